logic_op_arbiter: RTL and testbench
===================================

# logic_op_arbiter

Round-robin arbiter and sequencer that shares one registered bitwise logic unit (AND/OR/XOR/NOR) among four requesters in the femtoRV32 datapath, such as the ALU issue path, CSR set/clear logic and debug access. It accepts one operation at a time through a valid/ready handshake, computes the result in a dedicated execute cycle, and holds the tagged result until the consumer accepts it.

## Interface
- `N`, 32, operand/result width in bits
- `clk` in 1: single clock; all state updates on the rising edge
- `rst` in 1: synchronous, active-high reset
- `req_valid` in 4: per-requester request; bit i belongs to requester i
- `req_ready` out 4: one-hot grant/accept; at most one bit high
- `req_a` in 4*N: packed operand A; requester i uses bits [i*N +: N]
- `req_b` in 4*N: packed operand B; same packing as `req_a`
- `req_op` in 8: packed opcode, 2 bits per requester; 00 AND, 01 OR, 10 XOR, 11 NOR
- `resp_valid` out 1: result available
- `resp_id` out 2: index of the requester that owns the result
- `resp_data` out N: result
- `resp_ready` in 1: consumer accepts the result
- `busy` out 1: high whenever state is not IDLE

## Operation
- States: IDLE, EXEC, RESP. Register `ptr[1:0]` sets round-robin priority.
- IDLE: if any `req_valid` bit is set, the winner is the first set bit, searching upward from `ptr` modulo 4. `req_ready[winner]` is driven combinationally in this cycle only. The handshake completes at the clock edge: A, B, op and id are captured into operand registers, `ptr` becomes (winner+1) mod 4, and the state goes to EXEC. With no request, the state stays IDLE and `ptr` is unchanged.
- EXEC: `resp_data` is loaded with op(A,B) over the full N bits. NOR is ~(A|B). `resp_id` is loaded with the captured id and the state goes to RESP. This state always takes exactly one cycle.
- RESP: `resp_valid`=1. `resp_data` and `resp_id` hold stable until `resp_valid && resp_ready` at an edge, then the state returns to IDLE.
- `req_ready` is 0 in EXEC and RESP, so requests arriving in those states are ignored. Requesters hold `req_valid` and their operands until they are granted.
- Operand bits sampled are only those at the accepting edge. Later changes to `req_a`/`req_b`/`req_op` do not affect an in-flight result.
- No combinational path exists from `resp_ready` to `req_ready`. A new grant is issued no earlier than the IDLE cycle after the response is accepted.

## Timing
- Reset (`rst`=1 at an edge) sets: state IDLE, `ptr`=0, `resp_valid`=0, `resp_data`=0, `resp_id`=0, operand registers 0.
- While `rst`=1, `req_ready` is forced to 4'b0000 and `busy`=0.
- Reset mid-operation (in EXEC or RESP) abandons the transaction with no response. The next cycle is IDLE with `ptr`=0.
- Cycle sequence: accepted at the end of cycle T (IDLE), EXEC in T+1, `resp_valid` first high in T+2.
- If `resp_ready`=1 in T+2, then T+3 is IDLE and can grant again. Throughput is at best one operation per 3 cycles.
- Backpressure: each cycle `resp_ready`=0 in RESP adds one cycle. `resp_valid` never drops without a handshake, except on reset.
- Fairness: with all four requesting continuously, grant order is 0,1,2,3,0,… No requester waits more than 3 other grants.
- `busy` is registered with the state: high in EXEC and RESP, low in IDLE.

## Test plan
- **Reset values:** hold `rst` 2 cycles, with `req_valid`=4'b1111 during reset. Required: `req_ready`=0, `resp_valid`=0, `resp_data`=0, `busy`=0. The first grant after release goes to requester 0.
- **Single OR:** requester 2 sends A=0x0000_F0F0, B=0x0F0F_0000, op=01. Required: `req_ready`=4'b0100 in cycle T; `resp_valid`=1, `resp_id`=2 and `resp_data`=0x0F0F_F0F0 in T+2.
- **All ops:** A=0xFFFF_0000, B=0xFF00_FF00 from requester 0. Required results: AND 0xFF00_0000, OR 0xFFFF_FF00, XOR 0x00FF_FF00, NOR 0x0000_00FF.
- **Round-robin:** hold `req_valid`=4'b1111 with `resp_ready`=1. Required: grants in order 0,1,2,3,0, exactly 3 cycles apart. Then from `ptr`=2 with `req_valid`=4'b0011, the grant goes to 0 and the next to 1.
- **Backpressure and stability:** hold `resp_ready`=0 for 5 cycles in RESP while changing requester 1's operands. Required: `resp_data`/`resp_id` stay stable, `req_ready`=0 throughout, and the handshake happens only when `resp_ready` rises.
- **Reset mid-operation:** assert `rst` during EXEC. Required: no `resp_valid` pulse, and IDLE with `ptr`=0 on the next cycle after release.

Source files
------------

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter that shares one registered AND/OR/XOR/NOR unit among four
// requesters; one operation in flight, result held until the consumer accepts it.
module logic_op_arbiter #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req_valid,
  output logic [3:0]     req_ready,
  input  logic [4*N-1:0] req_a,
  input  logic [4*N-1:0] req_b,
  input  logic [7:0]     req_op,
  output logic           resp_valid,
  output logic [1:0]     resp_id,
  output logic [N-1:0]   resp_data,
  input  logic           resp_ready,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_t;

  state_t       state, state_nxt;
  logic [1:0]   ptr;
  logic [1:0]   winner;
  logic [1:0]   idx;
  logic         any_req;
  logic         accept;
  logic [N-1:0] op_a, op_b;
  op_t          op_code;
  logic [1:0]   op_id;
  logic [N-1:0] result;

  // Rotating priority search: the first valid bit at or above ptr (mod 4) wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    winner  = ptr;
    any_req = 1'b0;
    idx     = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!any_req && req_valid[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 4'b0000;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = EXEC;
          req_ready = 4'b0001 << winner;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (rst) req_ready = 4'b0000;
  end

  assign accept = (state == IDLE) && any_req && !rst;

  always_comb begin
    result = '0;
    case (op_code)
      OP_AND:  result = op_a & op_b;
      OP_OR:   result = op_a | op_b;
      OP_XOR:  result = op_a ^ op_b;
      OP_NOR:  result = ~(op_a | op_b);
      default: result = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= 2'd0;
      op_a      <= '0;
      op_b      <= '0;
      op_code   <= OP_AND;
      op_id     <= 2'd0;
      resp_data <= '0;
      resp_id   <= 2'd0;
    end else begin
      if (accept) begin
        op_a    <= req_a[winner*N +: N];
        op_b    <= req_b[winner*N +: N];
        op_code <= op_t'(req_op[{winner, 1'b0} +: 2]);
        op_id   <= winner;
        ptr     <= winner + 2'd1;
      end
      // Result and tag load only in EXEC, so they stay frozen throughout RESP.
      if (state == EXEC) begin
        resp_data <= result;
        resp_id   <= op_id;
      end
    end
  end

  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE) && !rst;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed bench for logic_op_arbiter: stimulus pushes expected responses into a
// scoreboard queue and a negedge monitor checks each accepted response.
module tb_logic_op_arbiter;

  localparam int N = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req_valid;
  logic [3:0]     req_ready;
  logic [4*N-1:0] req_a, req_b;
  logic [7:0]     req_op;
  logic           resp_valid;
  logic [1:0]     resp_id;
  logic [N-1:0]   resp_data;
  logic           resp_ready;
  logic           busy;

  typedef struct packed {
    logic [1:0]   id;
    logic [N-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_resp   = 0;
  int   cyc      = 0;

  logic [31:0] ops_exp [4] = '{32'hFF00_0000, 32'hFFFF_FF00, 32'h00FF_FF00, 32'h0000_00FF};
  logic [31:0] rr_a    [4] = '{32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 32'h4000_0000};
  logic [31:0] rr_exp  [4] = '{32'h1000_0F00, 32'h2000_0F00, 32'h3000_0F00, 32'h4000_0F00};

  logic_op_arbiter #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_ready (resp_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: a response is consumed when valid and ready are both high.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      n_resp++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got id %0d data %h with empty scoreboard", resp_id, resp_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_id", 64'(resp_id), 64'(e.id));
        check("resp_data", 64'(resp_data), 64'(e.data));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    req_a[id*N +: N] = a;
    req_b[id*N +: N] = b;
    req_op[id*2 +: 2] = op;
  endtask

  // Waits (bounded) for a grant, checks it is the expected one-hot, optionally
  // pushes the expected response, and returns just after the accepting edge.
  task automatic expect_grant(input int id, input bit push, input logic [31:0] exp_data, output int gcyc);
    bit got = 1'b0;
    gcyc = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (req_ready != 4'b0000) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL grant_timeout: got no grant, expected requester %0d", id);
    end else begin
      check("grant", 64'(req_ready), 64'(4'b0001 << id));
      gcyc = cyc;
      if (push) sb.push_back('{id: 2'(id), data: exp_data});
    end
    @(posedge clk); #1;
  endtask

  task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                       input logic [31:0] exp_data);
    int g;
    set_req(id, a, b, op);
    req_valid[id] = 1'b1;
    expect_grant(id, 1'b1, exp_data, g);
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_idle();
    bit got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy && !resp_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: got busy %0d, expected 0", busy);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int tg, prev, n0;
    rst        = 1'b1;
    req_valid  = 4'b1111;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    resp_ready = 1'b0;

    // Reset values with all requesters asserting.
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'h0);
    check("rst_resp_valid", 64'(resp_valid), 64'h0);
    check("rst_resp_data", 64'(resp_data), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    @(posedge clk); #1;
    rst        = 1'b0;
    resp_ready = 1'b1;
    expect_grant(0, 1'b1, 32'h0, tg);
    req_valid = 4'b0000;
    wait_idle();

    // Single OR with cycle-accurate timing.
    do_op(2, 32'h0000_F0F0, 32'h0F0F_0000, 2'b01, 32'h0F0F_F0F0);
    @(negedge clk);
    check("t1_busy", 64'(busy), 64'h1);
    check("t1_resp_valid", 64'(resp_valid), 64'h0);
    @(negedge clk);
    check("t2_resp_valid", 64'(resp_valid), 64'h1);
    check("t2_resp_id", 64'(resp_id), 64'h2);
    check("t2_resp_data", 64'(resp_data), 64'h0F0F_F0F0);
    @(negedge clk);
    check("t3_busy", 64'(busy), 64'h0);
    @(posedge clk); #1;

    // All four opcodes from requester 0.
    for (int op = 0; op < 4; op++) begin
      do_op(0, 32'hFFFF_0000, 32'hFF00_FF00, 2'(op), ops_exp[op]);
      wait_idle();
    end

    // Round-robin from ptr=0 with everyone requesting.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, rr_a[i], 32'h0000_0F00, 2'b01);
    req_valid = 4'b1111;
    prev = 0;
    for (int g = 0; g < 5; g++) begin
      expect_grant(g % 4, 1'b1, rr_exp[g % 4], tg);
      if (g > 0) check("rr_spacing", 64'(tg - prev), 64'd3);
      prev = tg;
    end
    req_valid = 4'b0000;
    wait_idle();
    do_op(1, rr_a[1], 32'h0000_0F00, 2'b01, rr_exp[1]);
    wait_idle();
    req_valid = 4'b0011;
    expect_grant(0, 1'b1, rr_exp[0], tg);
    req_valid[0] = 1'b0;
    expect_grant(1, 1'b1, rr_exp[1], tg);
    req_valid = 4'b0000;
    wait_idle();

    // Backpressure with requester 1 changing operands and re-requesting.
    resp_ready = 1'b0;
    do_op(1, 32'h1234_5678, 32'hFFFF_0000, 2'b10, 32'hEDCB_5678);
    @(negedge clk);
    n0 = n_resp;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      set_req(1, 32'hA5A5_0000 + 32'(i), 32'h0000_5A5A, 2'(i));
      req_valid[1] = 1'b1;
      @(negedge clk);
      check("bp_resp_valid", 64'(resp_valid), 64'h1);
      check("bp_resp_data", 64'(resp_data), 64'hEDCB_5678);
      check("bp_resp_id", 64'(resp_id), 64'h1);
      check("bp_req_ready", 64'(req_ready), 64'h0);
    end
    check("bp_no_early_accept", 64'(n_resp), 64'(n0));
    @(posedge clk); #1;
    resp_ready   = 1'b1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("bp_accepted", 64'(n_resp), 64'(n0 + 1));
    check("bp_idle_after", 64'(busy), 64'h0);
    @(posedge clk); #1;

    // Reset during EXEC abandons the transaction and clears ptr.
    set_req(1, 32'hDEAD_BEEF, 32'h0, 2'b00);
    req_valid[1] = 1'b1;
    expect_grant(1, 1'b0, 32'h0, tg);
    req_valid = 4'b0000;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_resp_valid", 64'(resp_valid), 64'h0);
    check("mid_rst_busy", 64'(busy), 64'h0);
    check("mid_rst_req_ready", 64'(req_ready), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_resp_valid", 64'(resp_valid), 64'h0);
    check("post_rst_busy", 64'(busy), 64'h0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) set_req(i, rr_a[i], 32'h0000_0F00, 2'b01);
    req_valid = 4'b1111;
    expect_grant(0, 1'b1, rr_exp[0], tg);
    req_valid = 4'b0000;
    wait_idle();

    check("scoreboard_empty", 64'(sb.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
